// File: rtl/fifo_burst_reader.sv
// Burst reader: pops wide words from a FIFO and streams exactly num_words
// narrow words (LSB lane first) on a valid/ready interface, then pulses done.
//
// state | meaning
// IDLE  | waiting for start; done pulses here
// FETCH | pop request while FIFO non-empty
// WAIT  | FIFO read data arrives, load shift register
// SEND  | present narrow lanes downstream
module fifo_burst_reader #(
  parameter int R_DATA_WIDTH = 64,
  parameter int O_DATA_WIDTH = 16,
  parameter int LEN_WIDTH    = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [LEN_WIDTH-1:0]    num_words,
  output logic                    read_request,
  input  logic                    empty_flag,
  input  logic [R_DATA_WIDTH-1:0] rd_data,
  output logic [O_DATA_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done
);

  localparam int RATIO  = R_DATA_WIDTH / O_DATA_WIDTH;
  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(RATIO - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SEND
  } state_t;

  state_t                  state, state_nxt;
  logic [LEN_WIDTH-1:0]    remaining, remaining_nxt;
  logic [LANE_W-1:0]       lane, lane_nxt;
  logic [R_DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic                    done_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      remaining <= '0;
      lane      <= '0;
      shreg     <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      lane      <= lane_nxt;
      shreg     <= shreg_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    lane_nxt      = lane;
    shreg_nxt     = shreg;
    done_nxt      = 1'b0;
    read_request  = 1'b0;
    out_valid     = 1'b0;
    out_data      = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (num_words != '0) begin
            remaining_nxt = num_words;
            state_nxt     = S_FETCH;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      S_FETCH: begin
        read_request = ~empty_flag;
        if (!empty_flag) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        shreg_nxt = rd_data;
        lane_nxt  = '0;
        state_nxt = S_SEND;
      end
      S_SEND: begin
        out_valid = 1'b1;
        out_data  = shreg[O_DATA_WIDTH-1:0];
        if (out_ready) begin
          remaining_nxt = remaining - LEN_WIDTH'(1);
          // Last word of the burst wins over lane position: leftover lanes are dropped.
          if (remaining == LEN_WIDTH'(1)) begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
          end else if (lane == LANE_LAST) begin
            state_nxt = S_FETCH;
          end else begin
            lane_nxt  = lane + LANE_W'(1);
            shreg_nxt = shreg >> O_DATA_WIDTH;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: per-cycle vector table plus
// hand-written sequences for multi-word, empty-FIFO and reset corner cases.
module tb_fifo_burst_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [11:0] num_words = '0;
  logic        read_request;
  logic        empty_flag;
  logic [63:0] rd_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        done;

  int n_vec  = 0;
  int n_fail = 0;

  fifo_burst_reader #(.R_DATA_WIDTH(64), .O_DATA_WIDTH(16), .LEN_WIDTH(12)) dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words),
    .read_request(read_request), .empty_flag(empty_flag), .rd_data(rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // FIFO model: data appears on rd_data the cycle after an accepted pop
  logic [63:0] mem [32];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pops = 0;
  int cyc = 0;
  int last_pop_cyc = -1;

  assign empty_flag = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (read_request && !empty_flag) begin
      rd_data      <= mem[rd_ptr];
      rd_ptr       <= rd_ptr + 1;
      pops         <= pops + 1;
      last_pop_cyc <= cyc;
    end
  end

  task automatic push(input logic [63:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        start;
    logic [11:0] nw;
    logic        rdy;
    logic        rr;
    logic        vld;
    logic [15:0] data;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t vt[$];

  function automatic void add(logic s, logic [11:0] nw, logic rdy, logic rr, logic vld,
                              logic [15:0] d, logic b, logic dn);
    vec_t v;
    v.start = s; v.nw = nw; v.rdy = rdy; v.rr = rr; v.vld = vld;
    v.data = d; v.busy = b; v.done = dn;
    vt.push_back(v);
  endfunction

  // Starts a burst with out_ready=1 and collects words until done or timeout.
  task automatic burst(input logic [11:0] nw, output logic [15:0] got[$], output int hs[$]);
    bit seen_done = 0;
    got.delete();
    hs.delete();
    start = 1'b1; num_words = nw; out_ready = 1'b1;
    #2; step(); start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      #2;
      if (done) begin seen_done = 1; break; end
      if (out_valid) begin got.push_back(out_data); hs.push_back(cyc); end
      step();
    end
    chk("burst_done", 64'(seen_done), 64'd1);
  endtask

  logic [15:0] got[$];
  int          hs[$];
  int          p0;

  initial begin
    // Test A: one wide word, 4 lanes, continuous ready
    add(1, 4, 1, 0, 0, 16'h0,    0, 0);
    add(0, 0, 1, 1, 0, 16'h0,    1, 0);
    add(0, 0, 1, 0, 0, 16'h0,    1, 0);
    add(0, 0, 1, 0, 1, 16'h0001, 1, 0);
    add(0, 0, 1, 0, 1, 16'h0002, 1, 0);
    add(0, 0, 1, 0, 1, 16'h0003, 1, 0);
    add(0, 0, 1, 0, 1, 16'h0004, 1, 0);
    add(0, 0, 1, 0, 0, 16'h0,    0, 1);
    add(0, 0, 1, 0, 0, 16'h0,    0, 0);
    // Zero-length burst
    add(1, 0, 1, 0, 0, 16'h0,    0, 0);
    add(0, 0, 1, 0, 0, 16'h0,    0, 1);
    add(0, 0, 1, 0, 0, 16'h0,    0, 0);
    // Test B: stall pattern 1,0,0,1 with an ignored start while busy
    add(1, 4, 1, 0, 0, 16'h0,    0, 0);
    add(0, 0, 1, 1, 0, 16'h0,    1, 0);
    add(0, 0, 1, 0, 0, 16'h0,    1, 0);
    add(0, 0, 1, 0, 1, 16'h000a, 1, 0);
    add(1, 1, 0, 0, 1, 16'h000b, 1, 0);
    add(0, 0, 0, 0, 1, 16'h000b, 1, 0);
    add(0, 0, 1, 0, 1, 16'h000b, 1, 0);
    add(0, 0, 1, 0, 1, 16'h000c, 1, 0);
    add(0, 0, 1, 0, 1, 16'h000d, 1, 0);
    add(0, 0, 1, 0, 0, 16'h0,    0, 1);

    // Reset state
    #3;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rreq", 64'(read_request), 64'd0);
    step(); step();
    reset = 1'b0;
    step();

    push(64'h0004_0003_0002_0001);
    push(64'h000d_000c_000b_000a);
    for (int i = 0; i < vt.size(); i++) begin
      start = vt[i].start; num_words = vt[i].nw; out_ready = vt[i].rdy;
      #2;
      chk($sformatf("v%0d_rreq", i), 64'(read_request), 64'(vt[i].rr));
      chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'(vt[i].vld));
      if (vt[i].vld) chk($sformatf("v%0d_data", i), 64'(out_data), 64'(vt[i].data));
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'(vt[i].busy));
      chk($sformatf("v%0d_done", i), 64'(done), 64'(vt[i].done));
      step();
    end
    start = 1'b0;
    chk("table_pops", 64'(pops), 64'd2);

    // Two wide words, 6 narrow words: second word's upper lanes dropped
    p0 = pops;
    push(64'h0054_0053_0052_0051);
    push(64'h0064_0063_0062_0061);
    burst(12'd6, got, hs);
    chk("b6_count", 64'(got.size()), 64'd6);
    if (got.size() == 6) begin
      chk("b6_w0", 64'(got[0]), 64'h51);
      chk("b6_w3", 64'(got[3]), 64'h54);
      chk("b6_w4", 64'(got[4]), 64'h61);
      chk("b6_w5", 64'(got[5]), 64'h62);
      chk("b6_pop2_cyc", 64'(last_pop_cyc), 64'(hs[3] + 1));
    end
    chk("b6_pops", 64'(pops - p0), 64'd2);
    step();

    // Empty FIFO at start, fill after 10 cycles
    start = 1'b1; num_words = 12'd1; out_ready = 1'b1;
    #2; step(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #2;
      chk($sformatf("empty_wait%0d", i), {62'd0, read_request, busy}, 64'b01);
      step();
    end
    push(64'h0074_0073_0072_0071);
    #2;
    chk("fill_rreq", 64'(read_request), 64'd1);
    step(); #2;
    chk("fill_wait_valid", 64'(out_valid), 64'd0);
    step(); #2;
    chk("fill_send_valid", 64'(out_valid), 64'd1);
    chk("fill_send_data", 64'(out_data), 64'h71);
    step(); #2;
    chk("fill_done", 64'(done), 64'd1);
    step();

    // Reset after two of four words delivered
    push(64'h0034_0033_0032_0031);
    start = 1'b1; num_words = 12'd4; out_ready = 1'b1;
    #2; step(); start = 1'b0;
    step(); step(); step(); step();
    #2;
    chk("pre_rst_data", 64'(out_data), 64'h33);
    reset = 1'b1;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_data", 64'(out_data), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_rreq", 64'(read_request), 64'd0);
    step();
    reset = 1'b0;
    step();
    p0 = pops;
    push(64'h0044_0043_0042_0041);
    burst(12'd4, got, hs);
    chk("post_rst_count", 64'(got.size()), 64'd4);
    if (got.size() == 4) begin
      chk("post_rst_w0", 64'(got[0]), 64'h41);
      chk("post_rst_w3", 64'(got[3]), 64'h44);
    end
    chk("post_rst_pops", 64'(pops - p0), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side consumer for the width-converting FIFO; drains it on behalf of a PE or router port.
- On a start pulse, pops wide words from the FIFO and delivers exactly num_words narrow words on a valid/ready output stream.
- Each wide word is serialised lane by lane, LSB lane first.
- Pulses done when the burst completes; sits between a GLB/NoC FIFO and the consuming PE scratchpad.

Parameters:
- R_DATA_WIDTH, 64, width of FIFO read data (wide word).
- O_DATA_WIDTH, 16, width of output word; R_DATA_WIDTH must be an integer power-of-two multiple of it.
- LEN_WIDTH, 12, width of the burst length field.
- Derived: RATIO = R_DATA_WIDTH/O_DATA_WIDTH; LANE_W = max(1, clog2(RATIO)).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle burst request; sampled only in IDLE.
- num_words  in  LEN_WIDTH  narrow words to deliver; sampled with start.
- read_request  out  1  pop request to FIFO (combinational).
- empty_flag  in  1  FIFO empty indication.
- rd_data  in  R_DATA_WIDTH  FIFO read data; valid the cycle after an accepted pop.
- out_data  out  O_DATA_WIDTH  current narrow word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts the word when out_valid & out_ready.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (async, any time including mid-burst): state=IDLE, remaining=0, lane=0, shift register=0, out_valid=0, out_data=0, busy=0, done=0, read_request=0. Any partially consumed wide word is discarded.
- States: IDLE, FETCH, WAIT, SEND.
- IDLE:
  - start & num_words!=0 -> latch remaining=num_words, go to FETCH, busy=1 from the next cycle.
  - start & num_words==0 -> done=1 next cycle, stay IDLE.
  - start outside IDLE is ignored.
- FETCH: read_request = ~empty_flag. If read_request=1, go to WAIT next cycle; else hold in FETCH indefinitely (no timeout).
- WAIT:
  - Capture rd_data into the shift register, lane=0, go to SEND.
  - read_request=0 and out_valid=0 in this state.
- SEND:
  - out_valid=1; out_data = shift register bits [O_DATA_WIDTH-1:0] (lane 0 = bits [15:0] first).
  - out_data and out_valid hold stable while out_ready=0.
  - On handshake: remaining decrements. Then:
    - remaining was 1 -> go to IDLE, busy=0, done=1 for exactly one cycle; unused lanes of the current wide word are dropped.
    - else lane==RATIO-1 -> go to FETCH.
    - else lane+1, shift register shifts right by O_DATA_WIDTH, stay in SEND.
- Throughput: one narrow word per cycle within a wide word. Exactly 2 bubble cycles (FETCH, WAIT) between wide words when the FIFO is non-empty.
- read_request is asserted only in FETCH; never more than one pop per wide word.
- RATIO==1: each pop yields one output word; lane is unused.
- busy = (state != IDLE). done never coincides with out_valid.

Test Plan:
- FIFO holds 0x0004_0003_0002_0001; start, num_words=4, out_ready=1 -> out_data 0x0001,0x0002,0x0003,0x0004 on 4 consecutive cycles; done pulses the cycle after the 4th; one pop total.
- FIFO holds 2 words; num_words=6 -> 6 words in lane order; second pop occurs 1 cycle after the 4th handshake; lanes 2-3 of word 2 dropped; exactly 2 pops.
- FIFO empty at start, fill after 10 cycles -> read_request stays 0 and busy=1 throughout the wait; streaming begins 2 cycles after empty_flag falls.
- out_ready toggles 1,0,0,1 during SEND -> out_data holds steady while stalled; no word lost or duplicated; remaining decrements only on handshakes.
- num_words=0 -> done pulses one cycle later; no pop, out_valid stays 0. A start issued while busy does not change remaining.
- Assert reset after 2 of 4 words delivered -> all outputs 0 immediately; a new start with num_words=4 then performs a fresh pop and delivers 4 new words.
